ps2_key_decoder: RTL and testbench

- Parametrised keyboard decoder sitting between PS2_Controller (byte stream) and game control logic.
- Tracks the PS/2 set-2 make/break protocol (F0 break prefix, E0 extended prefix) for a configurable table of NUM_KEYS keys.
- Per key: held level, single-cycle press pulse (typematic make codes suppressed) and single-cycle release pulse.
- Prefix timeout and sequence-error flagging; optional auto-repeat for the most recently pressed key.

---
 rtl/ps2_kbd_pkg.sv | 30 +++
 rtl/ps2_key_repeat.sv | 64 ++++++
 rtl/ps2_key_decoder.sv | 145 ++++++++++++++
 tb/tb_ps2_key_decoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 set-2 key decoder: prefix bytes, ignored
// bytes, prefix-FSM state encoding and the default key table.
package ps2_kbd_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_EXT_ENC     = 2'd1;
    localparam logic [1:0] ST_BRK_ENC     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_EXT     = ST_EXT_ENC,
        ST_BRK     = ST_BRK_ENC,
        ST_EXT_BRK = ST_EXT_BRK_ENC
    } ps2_state_t;

    // Key 0 sits in the low byte: 33, 1B, 23, then E0-prefixed 75.
    localparam logic [31:0] PS2_DEFAULT_CODES = {8'h75, 8'h23, 8'h1B, 8'h33};
    localparam logic [3:0]  PS2_DEFAULT_EXT   = 4'b1000;

    // Controller/keyboard housekeeping bytes that never carry a key code.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_key_repeat.sv
// Single auto-repeat slot: follows the most recently newly-pressed key and
// requests extra press pulses while it stays held.
module ps2_key_repeat
    import ps2_kbd_pkg::*;
#(
    parameter int NUM_KEYS      = 4,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] new_press,
    input  logic [NUM_KEYS-1:0] key_held,
    input  logic [NUM_KEYS-1:0] key_release_next,
    output logic [NUM_KEYS-1:0] rep_press
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic          armed_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_new;
    logic [CW-1:0] cnt_q;

    // Highest-indexed new press wins when several keys go down together.
    always_comb begin
        idx_new = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (new_press[i]) idx_new = IW'(i);
        end
    end

    // Counter loads N-1 so the pulse lands exactly N cycles after the load.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            armed_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else if (|new_press) begin
            armed_q <= 1'b1;
            idx_q   <= idx_new;
            cnt_q   <= CW'(REPEAT_DELAY - 1);
        end else if (armed_q) begin
            if (key_release_next[idx_q] || !key_held[idx_q]) begin
                armed_q <= 1'b0;
            end else if (cnt_q == '0) begin
                cnt_q <= CW'(REPEAT_PERIOD - 1);
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // A break arriving on the terminal cycle suppresses that repeat.
    always_comb begin
        rep_press = '0;
        if (armed_q && (cnt_q == '0) && key_held[idx_q] && !key_release_next[idx_q]) begin
            rep_press[idx_q] = 1'b1;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 make/break decoder for a table of NUM_KEYS keys.
// Optional auto-repeat of the last pressed key: define PS2_KEY_REPEAT_EN.
//
// state    | meaning
// ---------+-------------------------------------------
// IDLE     | no prefix pending, next code is a make
// EXT      | E0 seen, next code is an extended make
// BRK      | F0 seen, next code is a break
// EXT_BRK  | E0 F0 seen, next code is an extended break
module ps2_key_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int                    NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = PS2_DEFAULT_CODES,
    parameter logic [NUM_KEYS-1:0]   KEY_EXT        = PS2_DEFAULT_EXT,
    parameter int                    TIMEOUT_CYCLES = 50000,
    parameter int                    REPEAT_DELAY   = 25000000,
    parameter int                    REPEAT_PERIOD  = 5000000
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [7:0]          last_code,
    output logic                last_ext,
    output logic                seq_error
);

    localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    ps2_state_t    state_q, state_d;
    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_hit;
    logic          do_make, do_break, ext_c, seq_err_c;
    logic [NUM_KEYS-1:0] match, held_d, press_d, release_d, rep_press;

    // Prefix FSM state register.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state, make/break decode and error detection.
    always_comb begin
        state_d   = state_q;
        do_make   = 1'b0;
        do_break  = 1'b0;
        ext_c     = 1'b0;
        seq_err_c = 1'b0;
        tmo_hit   = 1'b0;
        if (rx_valid) begin
            if (is_ignored(rx_data)) begin
                state_d   = ST_IDLE;
                seq_err_c = (state_q != ST_IDLE);
            end else if (rx_data == PS2_EXT) begin
                state_d   = ST_EXT;
                seq_err_c = (state_q != ST_IDLE);
            end else if (rx_data == PS2_BRK) begin
                case (state_q)
                    ST_IDLE: state_d = ST_BRK;
                    ST_EXT:  state_d = ST_EXT_BRK;
                    default: seq_err_c = 1'b1;
                endcase
            end else begin
                state_d  = ST_IDLE;
                ext_c    = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
                do_make  = (state_q == ST_IDLE) || (state_q == ST_EXT);
                do_break = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
            end
        end else if ((state_q != ST_IDLE) && (tmo_cnt_q == TMO_LAST)) begin
            state_d   = ST_IDLE;
            seq_err_c = 1'b1;
            tmo_hit   = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_match
        assign match[i] = (rx_data == KEY_CODES[8*i +: 8]) && (ext_c == KEY_EXT[i]);
    end

    // Key level and edge pulses; only transitions of the held level pulse.
    always_comb begin
        held_d    = key_held;
        press_d   = '0;
        release_d = '0;
        if (do_make) begin
            held_d  = key_held | match;
            press_d = match & ~key_held;
        end else if (do_break) begin
            held_d    = key_held & ~match;
            release_d = match & key_held;
        end
    end

`ifdef PS2_KEY_REPEAT_EN
    ps2_key_repeat #(
        .NUM_KEYS      (NUM_KEYS),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_repeat (
        .CLOCK_50         (CLOCK_50),
        .resetn           (resetn),
        .new_press        (press_d),
        .key_held         (key_held),
        .key_release_next (release_d),
        .rep_press        (rep_press)
    );
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = REPEAT_DELAY[0] ^ REPEAT_PERIOD[0];
    assign rep_press = '0;
`endif

    // Prefix timeout: cleared by any byte, runs only while a prefix is pending.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn || rx_valid || tmo_hit) tmo_cnt_q <= '0;
        else if (state_q != ST_IDLE)        tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end

    // Registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            key_held    <= '0;
            key_press   <= '0;
            key_release <= '0;
            last_code   <= '0;
            last_ext    <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            key_held    <= held_d;
            key_press   <= press_d | rep_press;
            key_release <= release_d;
            seq_error   <= seq_err_c;
            if (do_make || do_break) begin
                last_code <= rx_data;
                last_ext  <= ext_c;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: each driven cycle pushes the expected
// outputs, a monitor pops and compares them one edge later.
module tb_ps2_key_decoder;

    localparam int TMO = 50000;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] key_held, key_press, key_release;
    logic [7:0] last_code;
    logic       last_ext, seq_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] held, press, rel;
        logic [7:0] code;
        logic       ext, err;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_key_decoder #(
        .NUM_KEYS       (4),
        .TIMEOUT_CYCLES (TMO),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (4)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .key_held    (key_held),
        .key_press   (key_press),
        .key_release (key_release),
        .last_code   (last_code),
        .last_ext    (last_ext),
        .seq_error   (seq_error)
    );

    // Scoreboard monitor: compare the oldest expectation just after each edge.
    always @(posedge CLOCK_50) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks += 6;
            if (key_held !== e.held) begin
                errors++; $display("FAIL %s key_held: got %b expected %b", e.name, key_held, e.held);
            end
            if (key_press !== e.press) begin
                errors++; $display("FAIL %s key_press: got %b expected %b", e.name, key_press, e.press);
            end
            if (key_release !== e.rel) begin
                errors++; $display("FAIL %s key_release: got %b expected %b", e.name, key_release, e.rel);
            end
            if (last_code !== e.code) begin
                errors++; $display("FAIL %s last_code: got %h expected %h", e.name, last_code, e.code);
            end
            if (last_ext !== e.ext) begin
                errors++; $display("FAIL %s last_ext: got %b expected %b", e.name, last_ext, e.ext);
            end
            if (seq_error !== e.err) begin
                errors++; $display("FAIL %s seq_error: got %b expected %b", e.name, seq_error, e.err);
            end
        end
    end

    // One clock of stimulus (byte when v=1, idle otherwise) plus its expectation.
    task automatic step(input logic [7:0] b, input logic v,
                        input logic [3:0] h, input logic [3:0] p, input logic [3:0] r,
                        input logic [7:0] c, input logic x, input logic er, input string nm);
        exp_t t;
        @(negedge CLOCK_50);
        rx_data  = b;
        rx_valid = v;
        t.held = h; t.press = p; t.rel = r; t.code = c; t.ext = x; t.err = er; t.name = nm;
        exp_q.push_back(t);
        @(posedge CLOCK_50);
        #2 rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        rx_valid = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        checks++;
        if ({key_held, key_press, key_release, last_code, last_ext, seq_error} !== 22'd0) begin
            errors++;
            $display("FAIL reset_state: got held=%b press=%b rel=%b code=%h ext=%b err=%b expected all zero",
                     key_held, key_press, key_release, last_code, last_ext, seq_error);
        end
        @(negedge CLOCK_50) resetn = 1'b1;
    endtask

    task automatic test_make_typematic();
        step(8'h33, 1, 4'b0001, 4'b0001, 4'b0000, 8'h33, 0, 0, "make_33");
        step(8'h00, 0, 4'b0001, 4'b0000, 4'b0000, 8'h33, 0, 0, "make_33_pulse_end");
        step(8'h33, 1, 4'b0001, 4'b0000, 4'b0000, 8'h33, 0, 0, "typematic_1");
        step(8'h33, 1, 4'b0001, 4'b0000, 4'b0000, 8'h33, 0, 0, "typematic_2");
    endtask

    task automatic test_break();
        step(8'hF0, 1, 4'b0001, 4'b0000, 4'b0000, 8'h33, 0, 0, "brk_prefix");
        step(8'h33, 1, 4'b0000, 4'b0000, 4'b0001, 8'h33, 0, 0, "break_33");
        step(8'h00, 0, 4'b0000, 4'b0000, 4'b0000, 8'h33, 0, 0, "break_pulse_end");
        step(8'hF0, 1, 4'b0000, 4'b0000, 4'b0000, 8'h33, 0, 0, "brk_prefix_2");
        step(8'h1B, 1, 4'b0000, 4'b0000, 4'b0000, 8'h1B, 0, 0, "break_not_held");
    endtask

    task automatic test_extended();
        step(8'hE0, 1, 4'b0000, 4'b0000, 4'b0000, 8'h1B, 0, 0, "ext_prefix");
        step(8'h75, 1, 4'b1000, 4'b1000, 4'b0000, 8'h75, 1, 0, "ext_make_75");
        step(8'h00, 0, 4'b1000, 4'b0000, 4'b0000, 8'h75, 1, 0, "ext_pulse_end");
        step(8'h75, 1, 4'b1000, 4'b0000, 4'b0000, 8'h75, 0, 0, "plain_75_unmatched");
        step(8'hE0, 1, 4'b1000, 4'b0000, 4'b0000, 8'h75, 0, 0, "ext_prefix_2");
        step(8'hF0, 1, 4'b1000, 4'b0000, 4'b0000, 8'h75, 0, 0, "ext_brk_prefix");
        step(8'h75, 1, 4'b0000, 4'b0000, 4'b1000, 8'h75, 1, 0, "ext_break_75");
    endtask

    task automatic test_timeout();
        int n;
        step(8'hF0, 1, 4'b0000, 4'b0000, 4'b0000, 8'h75, 1, 0, "tmo_prefix");
        n = 0;
        while (seq_error !== 1'b1 && n < TMO + 100) begin
            @(posedge CLOCK_50);
            #1;
            n++;
        end
        checks++;
        if (n != TMO) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TMO);
        end
        step(8'h00, 0, 4'b0000, 4'b0000, 4'b0000, 8'h75, 1, 0, "tmo_pulse_end");
        step(8'h23, 1, 4'b0100, 4'b0100, 4'b0000, 8'h23, 0, 0, "make_after_tmo");
    endtask

    task automatic test_protocol_errors();
        step(8'hFA, 1, 4'b0100, 4'b0000, 4'b0000, 8'h23, 0, 0, "ign_idle");
        step(8'hF0, 1, 4'b0100, 4'b0000, 4'b0000, 8'h23, 0, 0, "err_brk_prefix");
        step(8'hAA, 1, 4'b0100, 4'b0000, 4'b0000, 8'h23, 0, 1, "ign_in_brk");
        step(8'hE0, 1, 4'b0100, 4'b0000, 4'b0000, 8'h23, 0, 0, "ext_prefix_3");
        step(8'hE0, 1, 4'b0100, 4'b0000, 4'b0000, 8'h23, 0, 1, "double_e0");
        step(8'h1B, 1, 4'b0100, 4'b0000, 4'b0000, 8'h1B, 1, 0, "ext_1b_unmatched");
        step(8'h33, 1, 4'b0101, 4'b0001, 4'b0000, 8'h33, 0, 0, "make_33_again");
        step(8'hF0, 1, 4'b0101, 4'b0000, 4'b0000, 8'h33, 0, 0, "brk_prefix_3");
        step(8'hF0, 1, 4'b0101, 4'b0000, 4'b0000, 8'h33, 0, 1, "double_f0");
        step(8'h33, 1, 4'b0100, 4'b0000, 4'b0001, 8'h33, 0, 0, "break_after_f0f0");
    endtask

    task automatic test_reset_mid_sequence();
        step(8'hF0, 1, 4'b0100, 4'b0000, 4'b0000, 8'h33, 0, 0, "brk_before_reset");
        @(negedge CLOCK_50) resetn = 1'b0;
        @(negedge CLOCK_50) resetn = 1'b1;
        checks++;
        if (key_held !== 4'b0000 || key_release !== 4'b0000 || last_code !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_seq: got held=%b rel=%b code=%h expected 0000 0000 00",
                     key_held, key_release, last_code);
        end
        step(8'h33, 1, 4'b0001, 4'b0001, 4'b0000, 8'h33, 0, 0, "make_after_reset");
    endtask

    task automatic test_repeat();
        logic [3:0] rp;
        step(8'hF0, 1, 4'b0001, 4'b0000, 4'b0000, 8'h33, 0, 0, "rep_pre_brk");
        step(8'h33, 1, 4'b0000, 4'b0000, 4'b0001, 8'h33, 0, 0, "rep_pre_release");
        step(8'h33, 1, 4'b0001, 4'b0001, 4'b0000, 8'h33, 0, 0, "rep_new_press");
        for (int k = 1; k <= 20; k++) begin
`ifdef PS2_KEY_REPEAT_EN
            rp = (k == 10 || k == 14 || k == 18) ? 4'b0001 : 4'b0000;
`else
            rp = 4'b0000;
`endif
            step(8'h00, 0, 4'b0001, rp, 4'b0000, 8'h33, 0, 0, $sformatf("rep_hold_%0d", k));
        end
        step(8'hF0, 1, 4'b0001, 4'b0000, 4'b0000, 8'h33, 0, 0, "rep_brk_prefix");
        step(8'h33, 1, 4'b0000, 4'b0000, 4'b0001, 8'h33, 0, 0, "rep_release");
        for (int k = 0; k < 10; k++) begin
            step(8'h00, 0, 4'b0000, 4'b0000, 4'b0000, 8'h33, 0, 0, $sformatf("rep_disarmed_%0d", k));
        end
    endtask

    initial begin
        test_reset();
        test_make_typematic();
        test_break();
        test_extended();
        test_timeout();
        test_protocol_errors();
        test_reset_mid_sequence();
        test_repeat();
        repeat (3) @(posedge CLOCK_50);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
